if_id_skid_stage: RTL and testbench
===================================

Name: if_id_skid_stage

Overview:
- Parametrised IF/ID pipeline register with a 2-entry skid buffer, valid/ready handshake on both sides, stall hold and synchronous flush.
- Sits between the fetch unit (instruction memory + PC incrementer) and decode.
- Replaces the single-entry IF/ID latch so that fetch is not lost when decode back-pressures.
- Stores the instruction word and the instruction's own PC, computed as incoming PC+1 minus PC_OFFSET.

Parameters:
- INSTR_W, 32, instruction word width.
- PC_W, 10, program counter width.
- PC_OFFSET, 1, subtracted from pc_plus_1_in at capture so that pc_out matches the instruction's own address.
- NOP_WORD, 0, instruction value presented and stored on reset/flush/empty.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  fetch presents a word.
- in_ready  output  1  stage can accept.
- instr_in  input  INSTR_W  fetched instruction.
- pc_plus_1_in  input  PC_W  PC+1 from fetch.
- stall  input  1  hazard unit hold; 1 = no transfer to decode.
- flush  input  1  branch/jump squash, synchronous.
- out_valid  output  1  decode-side word valid.
- out_ready  input  1  decode can consume.
- instr_out  output  INSTR_W  instruction to decode.
- pc_out  output  PC_W  instruction's own PC.

Behaviour:
- Definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready & ~stall.
- Storage: main entry (head, drives outputs) and skid entry. Each entry holds instr and pc.
- States, held in a 2-bit occupancy register: EMPTY (0), ONE (main full), TWO (main + skid full).
- Transitions on posedge clk when flush=0:
  - EMPTY:
    - in_fire -> ONE, main <= input.
    - else stay EMPTY.
  - ONE:
    - in_fire & out_fire -> ONE, main <= input.
    - in_fire & ~out_fire -> TWO, skid <= input.
    - ~in_fire & out_fire -> EMPTY.
    - else hold.
  - TWO:
    - out_fire -> ONE, main <= skid.
    - else hold. in_fire cannot occur in TWO.
- Output and handshake signals:
  - in_ready = (state != TWO). Combinational from the state register only; no dependency on out_ready, so there is no comb path fetch<->decode.
  - out_valid = (state != EMPTY).
  - instr_out = main.instr when out_valid, else NOP_WORD.
  - pc_out = main.pc when out_valid, else 0.
- PC arithmetic:
  - Captured pc = pc_plus_1_in - PC_OFFSET, modulo 2^PC_W.
  - Wrap example: pc_plus_1_in=0 with PC_OFFSET=1 gives all-ones (10'h3FF).
  - Result is truncated to PC_W; there is no sign extension.
- Latency: a word accepted at edge N is visible on the outputs after edge N, with out_valid=1 from cycle N+1. Throughput is 1 word/cycle when out_ready=1 and stall=0.
- stall=1:
  - Outputs and main are frozen; out_fire=0.
  - Input is still accepted while state != TWO, so a stall of 2+ cycles fills skid, then in_ready=0.
- flush=1 (sync):
  - Next state EMPTY, both entries <= NOP_WORD/0.
  - A concurrent in_fire is discarded.
  - Flush has priority over stall and over out_fire.
  - in_ready is not forced low during flush; the accepted word is dropped.
- Reset asserted (reset=0), at any time including mid-transfer:
  - State immediately EMPTY, entries NOP_WORD/0.
  - out_valid=0, instr_out=NOP_WORD, pc_out=0, in_ready=1.
  - No transfer occurs on the edge where reset deasserts if reset is still low at that edge.
- Ordering: words leave in acceptance order; the skid word is never overtaken.

Optional Feature:
- Macro: IF_ID_STATS_EN.
- When defined, add two outputs:
  - stall_cnt [15:0]: counts cycles with out_valid & stall.
  - flush_cnt [15:0]: counts cycles with flush=1 while state != EMPTY.
- Both counters are saturating (hold at 16'hFFFF) and are cleared by reset.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Streaming: out_ready=1, stall=0, inputs {instr=0x8C010004, pc+1=1}, {0x00221820, 2}, {0xAC030008, 3} on consecutive cycles -> outputs one cycle later in order, pc_out=0,1,2, in_ready constantly 1.
- Skid fill: state ONE, stall=1 for 3 cycles with in_valid=1 -> first cycle accepted (state TWO), then in_ready=0; instr_out unchanged. Release stall -> skid word follows main word, no loss or duplication.
- Flush priority: state TWO, flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, instr_out=0x00000000, in_ready=1, incoming word never appears on output.
- PC wrap: pc_plus_1_in=10'd0 accepted -> pc_out=10'h3FF; with PC_OFFSET=0 override -> pc_out=0.
- Async reset mid-operation: state TWO, drop reset between clock edges -> out_valid=0, instr_out=NOP_WORD, in_ready=1 immediately, without waiting for a clock edge. After release, first accepted word appears normally.
- IF_ID_STATS_EN: 5 stalled-valid cycles plus 2 flushes of non-empty stage -> stall_cnt=5, flush_cnt=2. Saturation: force 65540 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with a two-entry skid buffer, valid/ready on both sides,
// stall hold and synchronous flush. Define IF_ID_STATS_EN to add stall/flush counters.
module if_id_skid_stage #(
    parameter int                   INSTR_W   = 32,
    parameter int                   PC_W      = 10,
    parameter int                   PC_OFFSET = 1,
    parameter logic [INSTR_W-1:0]   NOP_WORD  = {INSTR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_plus_1_in,
    input  logic               stall,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out
`ifdef IF_ID_STATS_EN
    ,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_r;
    logic [INSTR_W-1:0] main_instr_r;
    logic [PC_W-1:0]    main_pc_r;
    logic [INSTR_W-1:0] skid_instr_r;
    logic [PC_W-1:0]    skid_pc_r;

    logic               in_fire_s;
    logic               out_fire_s;
    logic [PC_W-1:0]    pc_cap_s;

    // Handshake depends only on the occupancy register, so fetch and decode never share a comb path.
    assign in_ready   = (state_r != ST_TWO);
    assign out_valid  = (state_r != ST_EMPTY);
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready & ~stall;
    assign pc_cap_s   = pc_plus_1_in - PC_W'(PC_OFFSET);
    assign instr_out  = out_valid ? main_instr_r : NOP_WORD;
    assign pc_out     = out_valid ? main_pc_r : {PC_W{1'b0}};

    // Occupancy state machine and entry storage; flush outranks stall and out_fire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_EMPTY;
            main_instr_r <= NOP_WORD;
            main_pc_r    <= {PC_W{1'b0}};
            skid_instr_r <= NOP_WORD;
            skid_pc_r    <= {PC_W{1'b0}};
        end else if (flush) begin
            state_r      <= ST_EMPTY;
            main_instr_r <= NOP_WORD;
            main_pc_r    <= {PC_W{1'b0}};
            skid_instr_r <= NOP_WORD;
            skid_pc_r    <= {PC_W{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_r      <= ST_ONE;
                        main_instr_r <= instr_in;
                        main_pc_r    <= pc_cap_s;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        state_r      <= ST_ONE;
                        main_instr_r <= instr_in;
                        main_pc_r    <= pc_cap_s;
                    end else if (in_fire_s) begin
                        state_r      <= ST_TWO;
                        skid_instr_r <= instr_in;
                        skid_pc_r    <= pc_cap_s;
                    end else if (out_fire_s) begin
                        state_r <= ST_EMPTY;
                    end else begin
                        state_r <= ST_ONE;
                    end
                end
                ST_TWO: begin
                    // The skid word moves to the head so it is never overtaken.
                    if (out_fire_s) begin
                        state_r      <= ST_ONE;
                        main_instr_r <= skid_instr_r;
                        main_pc_r    <= skid_pc_r;
                    end else begin
                        state_r <= ST_TWO;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef IF_ID_STATS_EN
    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'h0000;
            flush_cnt <= 16'h0000;
        end else begin
            if (out_valid && stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'h0001;
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (flush && (state_r != ST_EMPTY) && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'h0001;
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage; a second instance with PC_OFFSET=0 checks the offset override.
module tb_if_id_skid_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr_in;
    logic [9:0]  pc_plus_1_in;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic [9:0]  pc_out;
    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] instr_out2;
    logic [9:0]  pc_out2;
`ifdef IF_ID_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [15:0] stall_cnt2;
    logic [15:0] flush_cnt2;
`endif

    int vectors;
    int miscompares;

    if_id_skid_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .pc_plus_1_in(pc_plus_1_in), .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out), .pc_out(pc_out)
`ifdef IF_ID_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    if_id_skid_stage #(.PC_OFFSET(0)) dut_off0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .instr_in(instr_in), .pc_plus_1_in(pc_plus_1_in), .stall(stall), .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready), .instr_out(instr_out2), .pc_out(pc_out2)
`ifdef IF_ID_STATS_EN
        , .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [9:0] pcp1);
        in_valid     = v;
        instr_in     = ins;
        pc_plus_1_in = pcp1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; instr_in = 32'h0; pc_plus_1_in = 10'd0;
        stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
        step(); step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (instr_out !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h want 00000000", instr_out); end
        vectors++; if (pc_out !== 10'h0) begin miscompares++; $display("FAIL reset_pc got %h want 000", pc_out); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        #3 reset = 1'b1;
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_idle_valid got %b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [31:0] words [3];
        words[0] = 32'h8C010004; words[1] = 32'h00221820; words[2] = 32'hAC030008;
        out_ready = 1'b1; stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, words[i], 10'(i + 1));
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
            step();
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d] got %b want 1", i, out_valid); end
            vectors++; if (instr_out !== words[i]) begin miscompares++; $display("FAIL stream_instr[%0d] got %h want %h", i, instr_out, words[i]); end
            vectors++; if (pc_out !== 10'(i)) begin miscompares++; $display("FAIL stream_pc[%0d] got %0d want %0d", i, pc_out, i); end
        end
        drive(1'b0, 32'h0, 10'd0);
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain_valid got %b want 0", out_valid); end
        vectors++; if (instr_out !== 32'h0) begin miscompares++; $display("FAIL stream_drain_instr got %h want 00000000", instr_out); end
    endtask

    task automatic test_skid_fill();
        drive(1'b1, 32'h11111111, 10'd5);
        step();
        vectors++; if (instr_out !== 32'h11111111) begin miscompares++; $display("FAIL skid_main got %h want 11111111", instr_out); end
        stall = 1'b1;
        drive(1'b1, 32'h22222222, 10'd6);
        step();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL skid_full_ready got %b want 0", in_ready); end
        vectors++; if (instr_out !== 32'h11111111) begin miscompares++; $display("FAIL skid_hold_instr got %h want 11111111", instr_out); end
        drive(1'b1, 32'h33333333, 10'd7);
        step(); step();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL skid_stall_ready got %b want 0", in_ready); end
        vectors++; if (instr_out !== 32'h11111111) begin miscompares++; $display("FAIL skid_stall_instr got %h want 11111111", instr_out); end
        vectors++; if (pc_out !== 10'd4) begin miscompares++; $display("FAIL skid_stall_pc got %0d want 4", pc_out); end
        stall = 1'b0;
        drive(1'b0, 32'h0, 10'd0);
        step();
        vectors++; if (instr_out !== 32'h22222222) begin miscompares++; $display("FAIL skid_release_instr got %h want 22222222", instr_out); end
        vectors++; if (pc_out !== 10'd5) begin miscompares++; $display("FAIL skid_release_pc got %0d want 5", pc_out); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL skid_release_ready got %b want 1", in_ready); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL skid_drain_valid got %b want 0", out_valid); end
    endtask

    task automatic test_flush_priority();
        out_ready = 1'b0;
        drive(1'b1, 32'h44444444, 10'd9);
        step();
        drive(1'b1, 32'h55555555, 10'd10);
        step();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_pre_ready got %b want 0", in_ready); end
        flush = 1'b1; out_ready = 1'b1; stall = 1'b1;
        drive(1'b1, 32'h66666666, 10'd11);
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %b want 0", out_valid); end
        vectors++; if (instr_out !== 32'h0) begin miscompares++; $display("FAIL flush_instr got %h want 00000000", instr_out); end
        vectors++; if (pc_out !== 10'd0) begin miscompares++; $display("FAIL flush_pc got %0d want 0", pc_out); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %b want 1", in_ready); end
        flush = 1'b0; stall = 1'b0;
        drive(1'b0, 32'h0, 10'd0);
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_post_valid got %b want 0", out_valid); end
    endtask

    task automatic test_pc_wrap();
        out_ready = 1'b0;
        drive(1'b1, 32'h77777777, 10'd0);
        step();
        vectors++; if (pc_out !== 10'h3FF) begin miscompares++; $display("FAIL wrap_pc got %h want 3ff", pc_out); end
        vectors++; if (pc_out2 !== 10'h000) begin miscompares++; $display("FAIL wrap_pc_off0 got %h want 000", pc_out2); end
        vectors++; if (instr_out2 !== 32'h77777777) begin miscompares++; $display("FAIL wrap_instr_off0 got %h want 77777777", instr_out2); end
        vectors++; if ((out_valid2 !== 1'b1) || (in_ready2 !== 1'b1)) begin miscompares++; $display("FAIL wrap_hs_off0 got %b%b want 11", out_valid2, in_ready2); end
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 10'd0);
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_drain_valid got %b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h88888888, 10'd20);
        step();
        drive(1'b1, 32'h99999999, 10'd21);
        step();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL areset_pre_ready got %b want 0", in_ready); end
        #3 reset = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_valid got %b want 0", out_valid); end
        vectors++; if (instr_out !== 32'h0) begin miscompares++; $display("FAIL areset_instr got %h want 00000000", instr_out); end
        vectors++; if (pc_out !== 10'd0) begin miscompares++; $display("FAIL areset_pc got %0d want 0", pc_out); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL areset_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
        drive(1'b1, 32'hBBBBBBBB, 10'd25);
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_held_valid got %b want 0", out_valid); end
        #3 reset = 1'b1;
        drive(1'b1, 32'hAAAAAAAA, 10'd31);
        step();
        drive(1'b0, 32'h0, 10'd0);
        vectors++; if (instr_out !== 32'hAAAAAAAA) begin miscompares++; $display("FAIL areset_after_instr got %h want aaaaaaaa", instr_out); end
        vectors++; if (pc_out !== 10'd30) begin miscompares++; $display("FAIL areset_after_pc got %0d want 30", pc_out); end
        step();
    endtask

`ifdef IF_ID_STATS_EN
    task automatic test_stats();
        #3 reset = 1'b0;
        #2 reset = 1'b1;
        stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 32'hCCCCCCCC, 10'd1);
        step();
        drive(1'b0, 32'h0, 10'd0);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) step();
        stall = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b1, 32'hDDDDDDDD, 10'd2);
        step();
        drive(1'b0, 32'h0, 10'd0);
        flush = 1'b1;
        step();
        step();
        flush = 1'b0;
        vectors++; if (stall_cnt !== 16'd5) begin miscompares++; $display("FAIL stats_stall got %0d want 5", stall_cnt); end
        vectors++; if (flush_cnt !== 16'd2) begin miscompares++; $display("FAIL stats_flush got %0d want 2", flush_cnt); end
        #3 reset = 1'b0;
        #2 reset = 1'b1;
        drive(1'b1, 32'hEEEEEEEE, 10'd3);
        step();
        drive(1'b0, 32'h0, 10'd0);
        stall = 1'b1;
        for (int i = 0; i < 65540; i++) step();
        stall = 1'b0;
        vectors++; if (stall_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL stats_sat got %h want ffff", stall_cnt); end
        step();
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_streaming();
        test_skid_fill();
        test_flush_priority();
        test_pc_wrap();
        test_async_reset();
`ifdef IF_ID_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
